// File: rtl/hpm_event_counters.sv
// rtl/hpm_event_counters.sv - programmable hardware performance event counters
//
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   debug_mode_i    1 suspends all counting; register access still works
//   events_i        per-event increment amounts, INC_WIDTH bits per slot
//   addr_i, we_i,   SRAM-like register port; a write lands at the next edge
//   data_i
//   data_o          read data for addr_i, combinational from registered state
//   irq_o           registered overflow interrupt
module hpm_event_counters #(
    parameter int NUM_COUNTERS = 8,
    parameter int NUM_EVENTS   = 16,
    parameter int CNT_WIDTH    = 64,
    parameter int INC_WIDTH    = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             debug_mode_i,
    input  logic [NUM_EVENTS*INC_WIDTH-1:0]  events_i,
    input  logic [5:0]                       addr_i,
    input  logic                             we_i,
    input  logic [63:0]                      data_i,
    output logic [63:0]                      data_o,
    output logic                             irq_o
);

    localparam logic [5:0] ADDR_INHIBIT = 6'd32;
    localparam logic [5:0] ADDR_OVF     = 6'd33;
    localparam logic [5:0] ADDR_IRQ_EN  = 6'd34;

    logic [CNT_WIDTH-1:0]    cnt_q     [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]    cnt_d     [NUM_COUNTERS];
    logic [7:0]              code_q    [NUM_COUNTERS];
    logic [7:0]              code_d    [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] freeze_q, freeze_d;
    logic [NUM_COUNTERS-1:0] inhibit_q, inhibit_d;
    logic [NUM_COUNTERS-1:0] ovf_q, ovf_d;
    logic [NUM_COUNTERS-1:0] irq_en_q, irq_en_d;
    logic [NUM_COUNTERS-1:0] ovf_set;
    logic [NUM_COUNTERS-1:0] wr_cnt;
    logic                    irq_q;

    logic [INC_WIDTH-1:0]    evt       [NUM_EVENTS];
    logic [INC_WIDTH-1:0]    inc       [NUM_COUNTERS];
    logic [CNT_WIDTH:0]      sum       [NUM_COUNTERS];

    // Only the low bits of a write are architectural; the rest is ignored.
    logic unused_data;
    assign unused_data = ^data_i;

    always_comb begin
        for (int e = 0; e < NUM_EVENTS; e++) begin
            evt[e] = events_i[e*INC_WIDTH +: INC_WIDTH];
        end

        ovf_set   = '0;
        wr_cnt    = '0;
        freeze_d  = freeze_q;
        inhibit_d = inhibit_q;
        irq_en_d  = irq_en_q;

        for (int i = 0; i < NUM_COUNTERS; i++) begin
            code_d[i] = code_q[i];

            // Codes 0 and anything above NUM_EVENTS select no slot, so inc stays 0.
            inc[i] = '0;
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if (int'(code_q[i]) == e + 1) begin
                    inc[i] = evt[e];
                end
            end
            if (inhibit_q[i] || debug_mode_i || (freeze_q[i] && ovf_q[i])) begin
                inc[i] = '0;
            end

            // One extra bit on the sum captures the carry out of CNT_WIDTH.
            sum[i] = {1'b0, cnt_q[i]} + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, inc[i]};

            wr_cnt[i] = we_i && (addr_i == 6'(i));
            if (wr_cnt[i]) begin
                // A CPU write beats the increment and suppresses its overflow.
                cnt_d[i] = data_i[CNT_WIDTH-1:0];
            end else begin
                cnt_d[i]   = sum[i][CNT_WIDTH-1:0];
                ovf_set[i] = sum[i][CNT_WIDTH];
            end

            if (we_i && (addr_i == 6'(16 + i))) begin
                code_d[i]   = data_i[7:0];
                freeze_d[i] = data_i[8];
            end
        end

        if (we_i && addr_i == ADDR_INHIBIT) inhibit_d = data_i[NUM_COUNTERS-1:0];
        if (we_i && addr_i == ADDR_IRQ_EN)  irq_en_d  = data_i[NUM_COUNTERS-1:0];

        // Clear first, then set: a fresh overflow wins over a same-cycle W1C.
        ovf_d = ovf_q;
        if (we_i && addr_i == ADDR_OVF) ovf_d = ovf_d & ~data_i[NUM_COUNTERS-1:0];
        ovf_d = ovf_d | ovf_set;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i]  <= '0;
                code_q[i] <= '0;
            end
            freeze_q  <= '0;
            inhibit_q <= '0;
            ovf_q     <= '0;
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i]  <= cnt_d[i];
                code_q[i] <= code_d[i];
            end
            freeze_q  <= freeze_d;
            inhibit_q <= inhibit_d;
            ovf_q     <= ovf_d;
            irq_en_q  <= irq_en_d;
            // Built from next-state values so irq rises with the status bit.
            irq_q     <= |(ovf_d & irq_en_d);
        end
    end

    assign irq_o = irq_q;

    always_comb begin
        data_o = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (addr_i == 6'(i))      data_o = 64'(cnt_q[i]);
            if (addr_i == 6'(16 + i)) data_o = {55'd0, freeze_q[i], code_q[i]};
        end
        if (addr_i == ADDR_INHIBIT) data_o = 64'(inhibit_q);
        if (addr_i == ADDR_OVF)     data_o = 64'(ovf_q);
        if (addr_i == ADDR_IRQ_EN)  data_o = 64'(irq_en_q);
    end

endmodule

// File: doc/hpm_event_counters.md
Name: hpm_event_counters

Overview:
- Parametrised hardware performance monitor: NUM_COUNTERS programmable counters, each selecting one of NUM_EVENTS event sources.
- Generalises the fixed one-counter-per-event block:
  - multi-increment events, for multiple commit ports;
  - per-counter inhibit;
  - overflow status with interrupt;
  - freeze-on-overflow.
- Sits beside the CSR file; SRAM-like register port driven by the CSR regfile; event inputs come from caches, MMU, commit, issue and frontend.

Parameters:
NUM_COUNTERS, 8, number of programmable counters (1..16)
NUM_EVENTS, 16, number of event inputs (1..255)
CNT_WIDTH, 64, counter width in bits (8..64)
INC_WIDTH, 2, width of per-event increment (max increment 2^INC_WIDTH-1 per cycle)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
debug_mode_i  in  1  1 = counting suspended
events_i  in  NUM_EVENTS*INC_WIDTH  per-event increment amount this cycle
addr_i  in  6  register address
we_i  in  1  write enable
data_i  in  64  write data
data_o  out  64  read data (combinational from registered state)
irq_o  out  1  overflow interrupt, registered

Behaviour:
- Reset (async, rst_ni low), all state cleared:
  - counters, selectors, inhibit, ovf_status, ovf_irq_en = 0;
  - irq_o = 0; data_o reflects zeros.
- Register map (addr_i):
  - 0..NUM_COUNTERS-1: counter[i], low CNT_WIDTH bits; read zero-extended to 64.
  - 16..16+NUM_COUNTERS-1: sel[i]
    - bits[7:0] = event code: 0 = none; k in 1..NUM_EVENTS = events_i slot k-1; code > NUM_EVENTS = none.
    - bit[8] = freeze_on_ovf.
    - Other bits read 0.
  - 32: inhibit mask, bits[NUM_COUNTERS-1:0]; 1 = counter i does not count.
  - 33: ovf_status, bits[NUM_COUNTERS-1:0]; write-1-to-clear.
  - 34: ovf_irq_en, bits[NUM_COUNTERS-1:0].
  - Any other address: reads 0; writes ignored.
- Read is write-after-read: data_o shows the current registered value even when we_i is high; the write lands next cycle.
- Counting, per counter i, each cycle:
  - inc = events_i slot for sel[i] if all of the following hold, else 0:
    - code valid;
    - !inhibit[i];
    - !debug_mode_i;
    - !(freeze_on_ovf[i] && ovf_status[i]).
  - next = counter + inc, modulo 2^CNT_WIDTH.
  - If the addition carries out of CNT_WIDTH: ovf_status[i] set next cycle; counter holds the wrapped value.
- Simultaneous events:
  - CPU write to counter[i] in the same cycle as an increment: the write wins, the increment is dropped, no overflow is flagged.
  - W1C of ovf_status[i] in the same cycle as a new overflow of i: set wins, bit stays 1.
  - Write to sel[i] or inhibit: takes effect for counting from the next cycle; the current cycle uses the old values.
- Freeze: once ovf_status[i]=1 with freeze_on_ovf[i]=1, counter[i] holds until the status bit is cleared or the counter is written.
- irq_o register:
  - next value = |(ovf_status_d & ovf_irq_en_d), registered;
  - asserts one cycle after the overflow cycle (same cycle as the status bit becomes visible);
  - deasserts the cycle after the status is cleared or the enable is cleared.
- Debug mode: counting is stopped; register reads and writes still operate.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no pending writes survive.

Test Plan:
- Basic count:
  - Stimulus: sel[0]=3 (slot 2); events_i slot2 = 1 for 10 cycles, then slot2 = 3 for 2 cycles.
  - Response: counter[0]=16; other counters stay 0.
- Overflow with freeze, CNT_WIDTH=8:
  - Stimulus: counter[1]=0xFE; sel[1]=0x101 (event 1, freeze); ovf_irq_en=0x2; increment 3.
  - Response: counter[1]=0x01; ovf_status=0x2; irq_o=1 one cycle after the overflow cycle.
  - Further increments: counter[1] stays 0x01.
  - W1C 0x2: counter resumes counting; irq_o drops the next cycle.
- Write priority:
  - Stimulus: write counter[2]=0x100 in the same cycle as an increment of 2.
  - Response: counter[2]=0x100; data_o in the write cycle shows the old value.
- Inhibit and debug:
  - Stimulus: inhibit=0x1, or debug_mode_i=1, with events active.
  - Response: counter[0] unchanged; writes to counter[0]=5 still land.
- Status set/clear race:
  - Stimulus: W1C of ovf_status[3] in the same cycle as counter[3] overflows.
  - Response: ovf_status[3] stays 1.
- Invalid and unmapped:
  - Stimulus: sel code 0 or NUM_EVENTS+1; events high. Write to addr 40, then read addr 40.
  - Response: counter stays 0; write has no effect; read of addr 40 returns 0.
- Async reset: assert rst_ni mid-count → all registers 0 and irq_o=0 without waiting for a clock edge.
